// File: rtl/mode_switch_ctrl_pkg.sv
// Shared types and constants for the auto/manual source-select sequencer.
package mode_switch_pkg;

    typedef enum logic [1:0] {
        S_AUTO    = 2'd0,
        S_SW_MAN  = 2'd1,
        S_MANUAL  = 2'd2,
        S_SW_AUTO = 2'd3
    } mode_state_t;

    localparam int unsigned KEY_F1_BIT = 5;

    // Counter width able to hold 0..limit, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit == 0) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/mode_switch_ctrl_frame_tick_counter.sv
// Saturating frame-boundary counter; clear has priority over tick.
module frame_tick_counter
    import mode_switch_pkg::*;
#(
    parameter int unsigned LIMIT = 2,
    localparam int unsigned W    = cnt_width(LIMIT)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         tick,
    output logic [W-1:0] count,
    output logic         done
);

    localparam logic [W-1:0] LIMIT_W = W'(LIMIT);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_reg <= '0;
        end else if (tick && (count_reg != LIMIT_W)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;
    assign done  = (count_reg == LIMIT_W);

endmodule

// File: rtl/mode_switch_ctrl.sv
// Auto/manual select sequencer with frame holdoff and shot gating.
// Optional idle auto-revert from manual mode is enabled by AUTO_REVERT_EN.
module mode_switch_ctrl
    import mode_switch_pkg::*;
#(
    parameter int unsigned KEY_BIT        = KEY_F1_BIT,
    parameter int unsigned HOLDOFF_FRAMES = 2,
    parameter int unsigned IDLE_FRAMES    = 600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] keyboard_data,
    input  logic       frame_start,
    input  logic       shoot_auto,
    input  logic       shoot_manual,
    input  logic       manual_activity,
    output logic       sel_manual,
    output logic       blank,
    output logic       mode_changed,
    output logic       auto_revert,
    output logic [1:0] state_dbg
);

    localparam int unsigned HOLD_W = cnt_width(HOLDOFF_FRAMES);

    mode_state_t state_reg;
    logic key_prev_reg;
    logic sel_manual_reg, blank_reg, mode_changed_reg;

    logic req, in_switch, src_busy, commit, cancel, timeout;
    logic hold_done;
    logic [HOLD_W-1:0] hold_cnt;
    logic unused_ok;

    assign req       = keyboard_data[KEY_BIT] & ~key_prev_reg;
    assign in_switch = (state_reg == S_SW_MAN) || (state_reg == S_SW_AUTO);
    // The outgoing source is the one whose shot must finish before handover.
    assign src_busy  = (state_reg == S_SW_MAN) ? shoot_auto : shoot_manual;
    assign commit    = in_switch && hold_done && !src_busy;
    assign cancel    = in_switch && req && !commit;

    frame_tick_counter #(.LIMIT(HOLDOFF_FRAMES)) u_hold (
        .clk   (clk),
        .reset (reset),
        .clear (!in_switch || commit || cancel),
        .tick  (frame_start && in_switch),
        .count (hold_cnt),
        .done  (hold_done)
    );

`ifdef AUTO_REVERT_EN
    localparam int unsigned IDLE_W = cnt_width(IDLE_FRAMES);

    logic in_manual, idle_done, auto_revert_reg;
    logic [IDLE_W-1:0] idle_cnt;

    assign in_manual = (state_reg == S_MANUAL);
    assign timeout   = in_manual && idle_done;

    frame_tick_counter #(.LIMIT(IDLE_FRAMES)) u_idle (
        .clk   (clk),
        .reset (reset),
        .clear (!in_manual || manual_activity || timeout || req),
        .tick  (frame_start && in_manual),
        .count (idle_cnt),
        .done  (idle_done)
    );

    assign auto_revert = auto_revert_reg;
    assign unused_ok   = ^{keyboard_data, hold_cnt, idle_cnt};
`else
    assign timeout     = 1'b0;
    assign auto_revert = 1'b0;
    assign unused_ok   = ^{keyboard_data, hold_cnt, manual_activity};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= S_AUTO;
            key_prev_reg     <= 1'b0;
            sel_manual_reg   <= 1'b0;
            blank_reg        <= 1'b0;
            mode_changed_reg <= 1'b0;
`ifdef AUTO_REVERT_EN
            auto_revert_reg  <= 1'b0;
`endif
        end else begin
            key_prev_reg     <= keyboard_data[KEY_BIT];
            mode_changed_reg <= 1'b0;
`ifdef AUTO_REVERT_EN
            auto_revert_reg  <= 1'b0;
`endif
            unique case (state_reg)
                S_AUTO: begin
                    if (req) begin
                        state_reg <= S_SW_MAN;
                        blank_reg <= 1'b1;
                    end
                end
                S_SW_MAN: begin
                    if (commit) begin
                        state_reg        <= S_MANUAL;
                        sel_manual_reg   <= 1'b1;
                        blank_reg        <= 1'b0;
                        mode_changed_reg <= 1'b1;
                    end else if (cancel) begin
                        state_reg <= S_AUTO;
                        blank_reg <= 1'b0;
                    end
                end
                S_MANUAL: begin
                    // A key press coinciding with a timeout yields one transition.
                    if (timeout || req) begin
                        state_reg <= S_SW_AUTO;
                        blank_reg <= 1'b1;
`ifdef AUTO_REVERT_EN
                        auto_revert_reg <= timeout;
`endif
                    end
                end
                S_SW_AUTO: begin
                    if (commit) begin
                        state_reg        <= S_AUTO;
                        sel_manual_reg   <= 1'b0;
                        blank_reg        <= 1'b0;
                        mode_changed_reg <= 1'b1;
                    end else if (cancel) begin
                        state_reg <= S_MANUAL;
                        blank_reg <= 1'b0;
                    end
                end
                default: state_reg <= S_AUTO;
            endcase
        end
    end

    assign sel_manual   = sel_manual_reg;
    assign blank        = blank_reg;
    assign mode_changed = mode_changed_reg;
    assign state_dbg    = state_reg;

endmodule

// File: tb/tb_mode_switch_ctrl.sv
// Self-checking bench for mode_switch_ctrl (HOLDOFF_FRAMES=2, IDLE_FRAMES=4, plus a HOLDOFF_FRAMES=0 instance).
module tb_mode_switch_ctrl;
    import mode_switch_pkg::*;

    typedef struct packed {
        logic       sel;
        logic       blank;
        logic       mc;
        logic       ar;
        logic [1:0] st;
    } out_t;

    typedef struct {
        string name;
        logic  rst, key, fs, sa, sm, act;
        out_t  want;
    } vec_t;

    localparam logic [7:0] KEY_MASK = 8'h20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] keyboard_data = '0;
    logic       frame_start = 1'b0, shoot_auto = 1'b0, shoot_manual = 1'b0, manual_activity = 1'b0;
    logic       sel_manual, blank, mode_changed, auto_revert;
    logic [1:0] state_dbg;

    logic [7:0] kb0 = '0;
    logic       zero0 = 1'b0;
    logic       sel0, blank0, mc0, ar0;
    logic [1:0] st0;

    int   n_vec = 0;
    int   n_err = 0;
    out_t sb_q[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    mode_switch_ctrl #(.KEY_BIT(KEY_F1_BIT), .HOLDOFF_FRAMES(2), .IDLE_FRAMES(4)) dut (
        .clk(clk), .reset(reset), .keyboard_data(keyboard_data), .frame_start(frame_start),
        .shoot_auto(shoot_auto), .shoot_manual(shoot_manual), .manual_activity(manual_activity),
        .sel_manual(sel_manual), .blank(blank), .mode_changed(mode_changed),
        .auto_revert(auto_revert), .state_dbg(state_dbg)
    );

    mode_switch_ctrl #(.KEY_BIT(KEY_F1_BIT), .HOLDOFF_FRAMES(0), .IDLE_FRAMES(4)) dut0 (
        .clk(clk), .reset(reset), .keyboard_data(kb0), .frame_start(zero0),
        .shoot_auto(zero0), .shoot_manual(zero0), .manual_activity(zero0),
        .sel_manual(sel0), .blank(blank0), .mode_changed(mc0),
        .auto_revert(ar0), .state_dbg(st0)
    );

    function automatic vec_t V(input string name, input bit rst, key, fs, sa, sm, act,
                               input int st, input bit mc, input bit ar);
        vec_t v;
        v.name = name; v.rst = rst; v.key = key; v.fs = fs;
        v.sa = sa; v.sm = sm; v.act = act;
        v.want.st    = 2'(st);
        v.want.sel   = (st == 2) || (st == 3);
        v.want.blank = (st == 1) || (st == 3);
        v.want.mc    = mc;
        v.want.ar    = ar;
        return v;
    endfunction

    task automatic compare(input string name, input out_t got, input out_t want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got sel=%b blank=%b mc=%b ar=%b st=%0d, want sel=%b blank=%b mc=%b ar=%b st=%0d",
                     name, got.sel, got.blank, got.mc, got.ar, got.st,
                     want.sel, want.blank, want.mc, want.ar, want.st);
        end else begin
            $display("ok   %s: sel=%b blank=%b mc=%b ar=%b st=%0d",
                     name, got.sel, got.blank, got.mc, got.ar, got.st);
        end
    endtask

    task automatic step(input vec_t v);
        logic [7:0] noise;
        out_t got, want;
        @(negedge clk);
        noise           = 8'($urandom);
        reset           = v.rst;
        keyboard_data   = v.key ? (noise | KEY_MASK) : (noise & ~KEY_MASK);
        frame_start     = v.fs;
        shoot_auto      = v.sa;
        shoot_manual    = v.sm;
        manual_activity = v.act;
        sb_q.push_back(v.want);
        @(posedge clk);
        #1;
        got  = {sel_manual, blank, mode_changed, auto_revert, state_dbg};
        want = sb_q.pop_front();
        compare(v.name, got, want);
    endtask

    task automatic step0(input string name, input bit key, input int st, input bit mc);
        vec_t v;
        out_t got;
        v = V(name, 1'b0, key, 1'b0, 1'b0, 1'b0, 1'b0, st, mc, 1'b0);
        @(negedge clk);
        kb0 = key ? KEY_MASK : 8'h00;
        sb_q.push_back(v.want);
        @(posedge clk);
        #1;
        got = {sel0, blank0, mc0, ar0, st0};
        compare(name, got, sb_q.pop_front());
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //                name          rst key fs sa sm act st mc ar
        tbl.push_back(V("reset",        1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(V("idle",         0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(V("f1_rise",      0, 1, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(V("held_fs1",     0, 1, 1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(V("held",         0, 1, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(V("fs2",          0, 0, 1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(V("commit_man",   0, 0, 0, 0, 0, 0, 2, 1, 0));
        tbl.push_back(V("manual",       0, 0, 0, 0, 0, 0, 2, 0, 0));
        tbl.push_back(V("to_sw_auto",   0, 1, 0, 0, 0, 0, 3, 0, 0));
        tbl.push_back(V("swa_fs1",      0, 1, 1, 0, 0, 0, 3, 0, 0));
        tbl.push_back(V("swa_rel",      0, 0, 0, 0, 0, 0, 3, 0, 0));
        tbl.push_back(V("swa_cancel",   0, 1, 0, 0, 0, 0, 2, 0, 0));
        tbl.push_back(V("manual2",      0, 0, 0, 0, 0, 0, 2, 0, 0));
        tbl.push_back(V("to_sw_auto2",  0, 1, 0, 0, 0, 0, 3, 0, 0));
        tbl.push_back(V("swa_fs_a",     0, 0, 1, 0, 0, 0, 3, 0, 0));
        tbl.push_back(V("swa_fs_b",     0, 0, 1, 0, 0, 0, 3, 0, 0));
        tbl.push_back(V("swa_man_busy", 0, 0, 0, 0, 1, 0, 3, 0, 0));
        tbl.push_back(V("swa_commit",   0, 0, 0, 1, 0, 0, 0, 1, 0));
        tbl.push_back(V("auto",         0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(V("swm_enter",    0, 1, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(V("swm_fs1",      0, 0, 1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(V("swm_cancel",   0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(V("auto_fs",      0, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(V("swm_enter2",   0, 1, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(V("swm2_fs1",     0, 0, 1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(V("swm2_fs2",     0, 0, 1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(V("swm2_busy",    0, 0, 0, 1, 0, 0, 1, 0, 0));
        tbl.push_back(V("commit_vs_req",0, 1, 0, 0, 0, 0, 2, 1, 0));
        tbl.push_back(V("req_dropped",  0, 1, 0, 0, 0, 0, 2, 0, 0));
        tbl.push_back(V("manual3",      0, 0, 0, 0, 0, 0, 2, 0, 0));
        tbl.push_back(V("to_sw_auto3",  0, 1, 0, 0, 0, 0, 3, 0, 0));
        tbl.push_back(V("reset_in_swa", 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(V("post_reset",   0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(V("entry_fs",     0, 1, 1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(V("after_entry1", 0, 0, 1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(V("after_entry2", 0, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(V("after_entry3", 0, 0, 1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(V("entry_commit", 0, 0, 0, 0, 0, 0, 2, 1, 0));
        tbl.push_back(V("manual4",      0, 0, 0, 0, 0, 0, 2, 0, 0));

        foreach (tbl[i]) step(tbl[i]);

        // Outgoing manual shot completes; then auto shot held long inside S_SW_MAN.
        step(V("sh_to_swa",   0, 1, 0, 0, 0, 0, 3, 0, 0));
        step(V("sh_swa_fs1",  0, 0, 1, 0, 0, 0, 3, 0, 0));
        step(V("sh_swa_fs2",  0, 0, 1, 0, 0, 0, 3, 0, 0));
        step(V("sh_swa_cmt",  0, 0, 0, 0, 0, 0, 0, 1, 0));
        step(V("sh_to_swm",   0, 1, 0, 0, 0, 0, 1, 0, 0));
        step(V("sh_swm_fs1",  0, 0, 1, 0, 0, 0, 1, 0, 0));
        step(V("sh_swm_fs2",  0, 0, 1, 0, 0, 0, 1, 0, 0));
        for (int i = 0; i < 50; i++) begin
            step(V($sformatf("shoot_hold_%0d", i), 0, 0, (i % 7) == 3, 1, 0, 0, 1, 0, 0));
        end
        step(V("shoot_release", 0, 0, 0, 0, 0, 0, 2, 1, 0));
        step(V("sh_manual",     0, 0, 0, 0, 0, 0, 2, 0, 0));

`ifdef AUTO_REVERT_EN
        for (int i = 0; i < 4; i++) step(V($sformatf("idle_fs%0d", i), 0, 0, 1, 0, 0, 0, 2, 0, 0));
        step(V("auto_revert",   0, 0, 0, 0, 0, 0, 3, 0, 1));
        step(V("revert_after",  0, 0, 0, 0, 0, 0, 3, 0, 0));
        step(V("rv_fs1",        0, 0, 1, 0, 0, 0, 3, 0, 0));
        step(V("rv_fs2",        0, 0, 1, 0, 0, 0, 3, 0, 0));
        step(V("rv_commit",     0, 0, 0, 0, 0, 0, 0, 1, 0));
        step(V("act_to_swm",    0, 1, 0, 0, 0, 0, 1, 0, 0));
        step(V("act_fs1",       0, 0, 1, 0, 0, 0, 1, 0, 0));
        step(V("act_fs2",       0, 0, 1, 0, 0, 0, 1, 0, 0));
        step(V("act_commit",    0, 0, 0, 0, 0, 0, 2, 1, 0));
        for (int i = 0; i < 12; i++) begin
            step(V($sformatf("active_fs%0d", i), 0, 0, 1, 0, 0, (i % 3) == 2, 2, 0, 0));
        end
        for (int i = 0; i < 4; i++) step(V($sformatf("idle2_fs%0d", i), 0, 0, 1, 0, 0, 0, 2, 0, 0));
        step(V("revert_and_req", 0, 1, 0, 0, 0, 0, 3, 0, 1));
        step(V("revert_held",    0, 1, 0, 0, 0, 0, 3, 0, 0));
`else
        for (int i = 0; i < 6; i++) step(V($sformatf("no_revert_fs%0d", i), 0, 0, 1, 0, 0, 0, 2, 0, 0));
`endif

        // Zero-holdoff instance: F1 rise at N, switch state at N+1, commit at N+2.
        step0("h0_rise",   1'b1, 1, 1'b0);
        step0("h0_commit", 1'b1, 2, 1'b1);
        step0("h0_after",  1'b0, 2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
